// File: rtl/dec_to_bcd_entry.sv
// Decimal keypad entry.
// Ten asynchronous key lines are synchronised, debounced and priority-encoded
// to a BCD digit. Each accepted press is shifted into a packed BCD entry
// register. The newest digit sits in the low nibble.
module dec_to_bcd_entry #(
  parameter int DIGITS   = 4,
  parameter int DEBOUNCE = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [9:0]            key,
  input  logic                  clear,
  output logic [3:0]            bcd_out,
  output logic                  digit_valid,
  output logic                  multi_key,
  output logic                  overflow,
  output logic [4*DIGITS-1:0]   bcd_value,
  output logic [3:0]            digit_count,
  output logic                  full
);

  localparam int CW = (DEBOUNCE > 2) ? $clog2(DEBOUNCE) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE - 1);
  localparam logic [3:0]    DIG_MAX  = 4'(DIGITS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    HELD = 2'd2
  } state_t;

  state_t        state, state_nx;
  logic [9:0]    sync1, ks;
  logic [9:0]    pat, pat_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic          accept;
  logic [3:0]    enc;
  logic [3:0]    ones;
  logic          multi;
  logic [4*DIGITS-1:0] shifted;

  // Two-flop synchroniser for the asynchronous key lines.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= '0;
      ks    <= '0;
    end else begin
      sync1 <= key;
      ks    <= sync1;
    end
  end

  // Debounce FSM state, latched pattern and stability counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      pat   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      pat   <= pat_nx;
      cnt   <= cnt_nx;
    end
  end

  // Next-state logic.
  // A press is accepted once the pattern has stayed unchanged for DEBOUNCE
  // cycles after arming. A release needs DEBOUNCE quiet cycles.
  always_comb begin
    state_nx = state;
    pat_nx   = pat;
    cnt_nx   = cnt;
    accept   = 1'b0;
    unique case (state)
      IDLE: begin
        if (ks != '0) begin
          state_nx = ARM;
          pat_nx   = ks;
          cnt_nx   = '0;
        end
      end
      ARM: begin
        if (ks == '0) begin
          state_nx = IDLE;
          cnt_nx   = '0;
        end else if (ks != pat) begin
          pat_nx = ks;
          cnt_nx = '0;
        end else if (cnt == CNT_LAST) begin
          accept   = 1'b1;
          state_nx = HELD;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      HELD: begin
        if (ks != '0) begin
          cnt_nx = '0;
        end else if (cnt == CNT_LAST) begin
          state_nx = IDLE;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

  // Priority encoder (highest key wins) and a count of the pressed keys.
  always_comb begin
    enc  = '0;
    ones = '0;
    for (int unsigned i = 0; i < 10; i++) begin
      if (pat[i]) begin
        enc = 4'(i);
      end
      ones = ones + {3'b000, pat[i]};
    end
    multi = (ones > 4'd1);
  end

  // Shift path for the entry register. A single-digit register just replaces.
  generate
    if (DIGITS == 1) begin : g_one
      assign shifted = enc;
    end else begin : g_many
      assign shifted = {bcd_value[4*DIGITS-5:0], enc};
    end
  endgenerate

  // Output registers and the entry register.
  // A clear in the same cycle as an accept still reports the digit but
  // discards it and suppresses overflow.
  always_ff @(posedge clk) begin
    if (reset) begin
      bcd_out     <= '0;
      digit_valid <= 1'b0;
      multi_key   <= 1'b0;
      overflow    <= 1'b0;
      bcd_value   <= '0;
      digit_count <= '0;
      full        <= 1'b0;
    end else begin
      digit_valid <= accept;
      overflow    <= 1'b0;
      if (accept) begin
        bcd_out   <= enc;
        multi_key <= multi;
      end
      if (clear) begin
        bcd_value   <= '0;
        digit_count <= '0;
        full        <= 1'b0;
      end else if (accept) begin
        if (full) begin
          overflow <= 1'b1;
        end else begin
          bcd_value   <= shifted;
          digit_count <= digit_count + 4'd1;
          full        <= ((digit_count + 4'd1) == DIG_MAX);
        end
      end
    end
  end

endmodule

// File: tb/tb_dec_to_bcd_entry.sv
// Testbench for dec_to_bcd_entry.
// A run-length reference model checks every cycle. Directed scenarios add
// literal expectations, and a randomized phase with bounce, clear and reset
// follows.
module tb_dec_to_bcd_entry;

  localparam int DIGITS   = 4;
  localparam int DEBOUNCE = 4;
  localparam int LAT      = DEBOUNCE + 3;

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  key;
  logic        clear;
  logic [3:0]  bcd_out;
  logic        digit_valid;
  logic        multi_key;
  logic        overflow;
  logic [4*DIGITS-1:0] bcd_value;
  logic [3:0]  digit_count;
  logic        full;

  int tests = 0;
  int fails = 0;

  dec_to_bcd_entry #(.DIGITS(DIGITS), .DEBOUNCE(DEBOUNCE)) dut (
    .clk(clk), .reset(reset), .key(key), .clear(clear),
    .bcd_out(bcd_out), .digit_valid(digit_valid), .multi_key(multi_key),
    .overflow(overflow), .bcd_value(bcd_value), .digit_count(digit_count),
    .full(full)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Keys are delayed two samples. A press counts once DEBOUNCE+1 consecutive
  // identical non-zero samples are seen while not held. A held press releases
  // after DEBOUNCE consecutive zero samples.
  logic [9:0] m_s1, m_s2, m_prev;
  int         m_run, m_zrun, m_count;
  bit         m_held, model_ok = 0;
  longint     m_value;
  logic [3:0] e_bcd;
  bit         e_valid, e_multi, e_ovf;
  longint     mask = (64'd1 << (4*DIGITS)) - 1;

  function automatic int top_idx(input logic [9:0] p);
    for (int i = 9; i >= 0; i--) if (p[i]) return i;
    return 0;
  endfunction

  task automatic model_step();
    logic [9:0] s;
    bit acc;
    acc = 0;
    if (reset) begin
      m_s1 = '0; m_s2 = '0; m_prev = '0;
      m_run = 0; m_zrun = 0; m_held = 0;
      m_value = 0; m_count = 0;
      e_bcd = '0; e_valid = 0; e_multi = 0; e_ovf = 0;
      return;
    end
    s = m_s2; m_s2 = m_s1; m_s1 = key;
    e_valid = 0; e_ovf = 0;
    if (m_held) begin
      if (s == '0) begin
        m_zrun++;
        if (m_zrun == DEBOUNCE) begin m_held = 0; m_run = 0; end
      end else m_zrun = 0;
    end else begin
      if (s == '0) m_run = 0;
      else if (m_run > 0 && s == m_prev) m_run++;
      else m_run = 1;
      m_prev = s;
      if (m_run == DEBOUNCE + 1) acc = 1;
    end
    if (acc) begin
      m_held = 1; m_zrun = 0; m_run = 0;
      e_bcd = 4'(top_idx(s));
      e_multi = ($countones(s) > 1);
      e_valid = 1;
      if (clear) begin m_value = 0; m_count = 0; end
      else if (m_count == DIGITS) e_ovf = 1;
      else begin m_value = ((m_value * 16) + top_idx(s)) & mask; m_count++; end
    end else if (clear) begin
      m_value = 0; m_count = 0;
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
    model_ok = 1;
  end

  // Per-cycle comparison against the model, away from the active edge.
  initial forever begin
    @(negedge clk);
    if (model_ok) begin
      check("m_bcd_out", bcd_out, e_bcd);
      check("m_digit_valid", digit_valid, e_valid);
      if (e_valid) check("m_multi_key", multi_key, e_multi);
      check("m_overflow", overflow, e_ovf);
      check("m_bcd_value", bcd_value, m_value);
      check("m_digit_count", digit_count, m_count);
      check("m_full", full, (m_count == DIGITS));
    end
  end

  // ---------------- directed helpers ----------------
  task automatic edge_step();
    @(posedge clk); @(negedge clk);
  endtask

  task automatic wait_valid(input int maxc, output int n);
    n = -1;
    for (int i = 1; i <= maxc; i++) begin
      edge_step();
      if (digit_valid) begin n = i; return; end
    end
  endtask

  task automatic release_keys();
    key = '0;
    repeat (DEBOUNCE + 6) edge_step();
  endtask

  task automatic press(input logic [9:0] p, input string name);
    int n;
    key = p;
    wait_valid(40, n);
    check({name, "_latency"}, n, LAT);
    repeat (3) edge_step();
    release_keys();
  endtask

  task automatic pulse_clear();
    clear = 1'b1; edge_step(); clear = 1'b0;
  endtask

  initial begin
    int n;
    reset = 1'b1; key = '0; clear = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_bcd_out", bcd_out, 0);
    check("rst_valid", digit_valid, 0);
    check("rst_value", bcd_value, 0);
    check("rst_count", digit_count, 0);
    check("rst_full", full, 0);
    check("rst_ovf", overflow, 0);
    reset = 1'b0;
    edge_step();

    // 1: single clean press of 7
    key = 10'(1 << 7);
    wait_valid(40, n);
    check("t1_latency", n, LAT);
    check("t1_bcd_out", bcd_out, 7);
    check("t1_multi", multi_key, 0);
    edge_step();
    check("t1_pulse_width", digit_valid, 0);
    check("t1_value", bcd_value, 16'h0007);
    check("t1_count", digit_count, 1);
    repeat (12) edge_step();
    release_keys();

    // 2: key 5 bouncing, then stable; last toggle at c=8
    for (int c = 0; c < 10; c++) begin
      key = ((c / 2) % 2 == 0) ? 10'(1 << 5) : 10'd0;
      edge_step();
      check("t2_bounce_quiet", digit_valid, 0);
    end
    wait_valid(40, n);
    check("t2_latency_after_toggle", n + 2, LAT);
    check("t2_bcd_out", bcd_out, 5);
    check("t2_value", bcd_value, 16'h0075);
    repeat (3) edge_step();
    release_keys();

    // 3: keys 3 and 8 together, then 1 alone
    pulse_clear();
    key = 10'(1 << 3) | 10'(1 << 8);
    wait_valid(40, n);
    check("t3_latency", n, LAT);
    check("t3_bcd_out", bcd_out, 8);
    check("t3_multi", multi_key, 1);
    release_keys();
    key = 10'(1 << 1);
    wait_valid(40, n);
    check("t3b_bcd_out", bcd_out, 1);
    check("t3b_multi", multi_key, 0);
    edge_step();
    check("t3b_value", bcd_value, 16'h0081);
    release_keys();

    // 4: fill the register, then overflow
    pulse_clear();
    for (int d = 1; d <= 4; d++) press(10'(1 << d), "t4_press");
    check("t4_value", bcd_value, 16'h1234);
    check("t4_full", full, 1);
    check("t4_count", digit_count, 4);
    key = 10'(1 << 5);
    wait_valid(40, n);
    check("t4_5th_bcd", bcd_out, 5);
    check("t4_5th_ovf", overflow, 1);
    check("t4_5th_value", bcd_value, 16'h1234);
    release_keys();

    // 5: clear in the accept cycle of digit 9, while full
    key = 10'(1 << 9);
    repeat (LAT - 1) begin
      edge_step();
      check("t5_early", digit_valid, 0);
    end
    clear = 1'b1;
    edge_step();
    clear = 1'b0;
    check("t5_valid", digit_valid, 1);
    check("t5_bcd", bcd_out, 9);
    check("t5_value", bcd_value, 0);
    check("t5_count", digit_count, 0);
    check("t5_ovf", overflow, 0);
    release_keys();

    // 6: reset while arming with key 2 held
    key = 10'(1 << 2);
    repeat (4) edge_step();
    reset = 1'b1;
    edge_step();
    reset = 1'b0;
    check("t6_rst_value", bcd_value, 0);
    check("t6_rst_bcd", bcd_out, 0);
    check("t6_rst_valid", digit_valid, 0);
    wait_valid(40, n);
    check("t6_latency", n, LAT);
    check("t6_bcd", bcd_out, 2);
    release_keys();

    // Randomized phase: single/multi presses, bounce, gaps, clear and reset.
    for (int it = 0; it < 300; it++) begin
      logic [9:0] p;
      int len;
      if ($urandom_range(0, 3) == 0) p = 10'($urandom_range(0, 1023));
      else p = 10'(1 << $urandom_range(0, 9));
      len = $urandom_range(1, 14);
      for (int c = 0; c < len; c++) begin
        key   = ($urandom_range(0, 9) == 0) ? 10'($urandom_range(0, 1023)) : p;
        clear = ($urandom_range(0, 24) == 0);
        reset = ($urandom_range(0, 199) == 0);
        edge_step();
      end
      clear = 1'b0; reset = 1'b0;
      key = '0;
      repeat ($urandom_range(0, DEBOUNCE + 4)) edge_step();
    end
    release_keys();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Global time bound.
  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete, tests=%0d", tests);
    $fatal(1);
  end

endmodule
